// File: rtl/regfile_2r1w.sv
// Register file with two combinational read ports and one synchronous write port.
// Optional hardwired-zero register 0 and optional same-cycle write-to-read bypass.

module regfile_2r1w_rdport #(
    parameter int WIDTH  = 32,
    parameter int DEPTH  = 32,
    parameter int ADDR_W = 5
) (
    input  logic                            rst_n,
    input  logic [DEPTH-1:0][WIDTH-1:0]     regs,
    input  logic [ADDR_W-1:0]               raddr,
    input  logic                            byp,
    input  logic [WIDTH-1:0]                wdata,
    output logic [WIDTH-1:0]                rdata
);
    logic [WIDTH-1:0] sel;

    // Flat AND-OR selector: an address past DEPTH matches nothing and reads 0.
    always_comb begin
        sel = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (raddr == ADDR_W'(i)) sel = sel | regs[i];
        end
        if (!rst_n)   rdata = '0;
        else if (byp) rdata = wdata;
        else          rdata = sel;
    end
endmodule

module regfile_2r1w #(
    parameter int WIDTH    = 32,
    parameter int DEPTH    = 32,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 0,
    localparam int ADDR_W  = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [WIDTH-1:0]  wdata,
    input  logic [ADDR_W-1:0] raddr_a,
    input  logic [ADDR_W-1:0] raddr_b,
    output logic [WIDTH-1:0]  rdata_a,
    output logic [WIDTH-1:0]  rdata_b
);
    localparam int NUM_RD = 2;

    logic [DEPTH-1:0][WIDTH-1:0]  mem;
    logic [DEPTH-1:0]             wen;
    logic                         wr_hit;
    logic [NUM_RD-1:0][ADDR_W-1:0] raddr;
    logic [NUM_RD-1:0][WIDTH-1:0] rdata;
    logic [NUM_RD-1:0]            byp;

    assign raddr   = {raddr_b, raddr_a};
    assign rdata_a = rdata[0];
    assign rdata_b = rdata[1];

    // One-hot write decode; register 0 is excluded when hardwired, so it keeps its reset 0.
    always_comb begin
        wen = '0;
        for (int i = 0; i < DEPTH; i++) begin
            wen[i] = we && (waddr == ADDR_W'(i)) && !(ZERO_REG != 0 && i == 0);
        end
    end

    assign wr_hit = |wen;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mem <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (wen[i]) mem[i] <= wdata;
            end
        end
    end

    for (genvar p = 0; p < NUM_RD; p++) begin : g_rd
        // Bypass only fires for writes that will actually land in storage.
        assign byp[p] = (BYPASS != 0) && wr_hit && (waddr == raddr[p]);

        regfile_2r1w_rdport #(
            .WIDTH (WIDTH),
            .DEPTH (DEPTH),
            .ADDR_W(ADDR_W)
        ) u_rd (
            .rst_n(rst_n),
            .regs (mem),
            .raddr(raddr[p]),
            .byp  (byp[p]),
            .wdata(wdata),
            .rdata(rdata[p])
        );
    end
endmodule

// File: tb/tb_regfile_2r1w.sv
// Scoreboard bench for regfile_2r1w: three configurations share one stimulus stream;
// stimulus pushes hand-computed expectations, a negedge monitor pops and compares.

module tb_regfile_2r1w;
    logic        clk = 1'b0;
    logic        rst_n, we;
    logic [4:0]  waddr, raddr_a, raddr_b;
    logic [31:0] wdata;
    logic [31:0] r0a, r0b, r1a, r1b;
    logic [15:0] r2a, r2b;

    always #5 clk = ~clk;

    // u0: defaults (ZERO_REG=1, BYPASS=0)
    regfile_2r1w u0 (
        .clk(clk), .rst_n(rst_n), .we(we), .waddr(waddr), .wdata(wdata),
        .raddr_a(raddr_a), .raddr_b(raddr_b), .rdata_a(r0a), .rdata_b(r0b)
    );

    // u1: ordinary register 0, bypass on
    regfile_2r1w #(.ZERO_REG(0), .BYPASS(1)) u1 (
        .clk(clk), .rst_n(rst_n), .we(we), .waddr(waddr), .wdata(wdata),
        .raddr_a(raddr_a), .raddr_b(raddr_b), .rdata_a(r1a), .rdata_b(r1b)
    );

    // u2: non-power-of-two depth, narrow width
    regfile_2r1w #(.WIDTH(16), .DEPTH(24)) u2 (
        .clk(clk), .rst_n(rst_n), .we(we), .waddr(waddr), .wdata(wdata[15:0]),
        .raddr_a(raddr_a), .raddr_b(raddr_b), .rdata_a(r2a), .rdata_b(r2b)
    );

    typedef struct {
        string       name;
        int          dut;
        logic [31:0] ea;
        logic [31:0] eb;
    } exp_t;

    exp_t sbq[$];
    int   total = 0;
    int   bad   = 0;

    task automatic push(input string n, input int d, input logic [31:0] a, input logic [31:0] b);
        exp_t e;
        e.name = n; e.dut = d; e.ea = a; e.eb = b;
        sbq.push_back(e);
    endtask

    task automatic chk3(input string n,
                        input logic [31:0] a0, input logic [31:0] b0,
                        input logic [31:0] a1, input logic [31:0] b1,
                        input logic [31:0] a2, input logic [31:0] b2);
        push(n, 0, a0, b0);
        push(n, 1, a1, b1);
        push(n, 2, a2, b2);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [4:0] a, input logic [31:0] d);
        we = 1'b1; waddr = a; wdata = d;
        tick();
        we = 1'b0;
    endtask

    function automatic logic [31:0] zr(input int x);
        return (x == 0) ? 32'h0 : 32'hA5A5_0000 + 32'(x);
    endfunction

    function automatic logic [31:0] sm(input int x);
        return (x == 0 || x >= 24) ? 32'h0 : 32'(x);
    endfunction

    // Monitor: outputs are sampled on the falling edge, away from the write edge.
    exp_t        m;
    logic [31:0] aa, ab;
    always @(negedge clk) begin
        while (sbq.size() > 0) begin
            m = sbq.pop_front();
            case (m.dut)
                0:       begin aa = r0a; ab = r0b; end
                1:       begin aa = r1a; ab = r1b; end
                default: begin aa = {16'h0, r2a}; ab = {16'h0, r2b}; end
            endcase
            total++;
            if (aa !== m.ea || ab !== m.eb) begin
                bad++;
                $display("FAIL %s dut%0d: got a=%h b=%h want a=%h b=%h",
                         m.name, m.dut, aa, ab, m.ea, m.eb);
            end
        end
    end

    initial begin
        rst_n = 1'b0; we = 1'b0; waddr = '0; wdata = '0; raddr_a = '0; raddr_b = '0;
        tick();
        raddr_a = 5; raddr_b = 5;
        chk3("rst_force", 0, 0, 0, 0, 0, 0);
        tick();
        rst_n = 1'b1;

        // Fill, then reset and confirm everything clears
        for (int i = 1; i < 32; i++) wr(5'(i), 32'(i + 100));
        raddr_a = 5; raddr_b = 31;
        chk3("pre_rst", 105, 131, 105, 131, 105, 0);
        tick();
        rst_n = 1'b0;
        chk3("rst_low_rd", 0, 0, 0, 0, 0, 0);
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 32; i++) begin
            raddr_a = 5'(i); raddr_b = 5'(31 - i);
            chk3("rst_clear", 0, 0, 0, 0, 0, 0);
            tick();
        end

        // Write/read sweep with crossed port addresses
        for (int i = 0; i < 32; i++) wr(5'(i), 32'hA5A5_0000 + 32'(i));
        for (int i = 0; i < 32; i++) begin
            raddr_a = 5'(i); raddr_b = 5'(31 - i);
            chk3("sweep", zr(i), zr(31 - i),
                 32'hA5A5_0000 + 32'(i), 32'hA5A5_0000 + 32'(31 - i),
                 sm(i), sm(31 - i));
            tick();
        end

        // Register 0 write
        we = 1'b1; waddr = 0; wdata = 32'hFFFF_FFFF; raddr_a = 0; raddr_b = 0;
        chk3("zero_pre", 0, 0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 0);
        tick();
        we = 1'b0;
        chk3("zero_post", 0, 0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 0);
        tick();

        // Bypass vs stored value on both ports
        wr(7, 32'h11);
        we = 1'b1; waddr = 7; wdata = 32'h22; raddr_a = 7; raddr_b = 7;
        chk3("byp_pre", 32'h11, 32'h11, 32'h22, 32'h22, 32'h11, 32'h11);
        tick();
        we = 1'b0;
        chk3("byp_post", 32'h22, 32'h22, 32'h22, 32'h22, 32'h22, 32'h22);
        tick();

        // Reset beats a same-edge write and the bypass path
        rst_n = 1'b0; we = 1'b1; waddr = 3; wdata = 32'h55; raddr_a = 3; raddr_b = 3;
        chk3("rstw_pre", 0, 0, 0, 0, 0, 0);
        tick();
        rst_n = 1'b1; we = 1'b0;
        chk3("rstw_post", 0, 0, 0, 0, 0, 0);
        tick();

        // Out-of-range addressing on the 24-deep instance
        wr(5, 32'h0505);
        wr(23, 32'h1234);
        wr(27, 32'hBEEF);
        raddr_a = 27; raddr_b = 23;
        chk3("d24_rd", 32'hBEEF, 32'h1234, 32'hBEEF, 32'h1234, 0, 32'h1234);
        tick();
        for (int i = 24; i < 32; i++) begin
            raddr_a = 5'(i); raddr_b = 5'(i - 24);
            push("d24_oor", 2, 0, (i == 29) ? 32'h0505 : 32'h0);
            push("d24_oor", 0, (i == 27) ? 32'hBEEF : 32'h0, (i == 29) ? 32'h0505 : 32'h0);
            tick();
        end
        raddr_a = 23; raddr_b = 5;
        push("d24_keep", 2, 32'h1234, 32'h0505);
        tick();

        for (int k = 0; k < 10 && sbq.size() > 0; k++) @(negedge clk);
        #1;
        if (sbq.size() > 0) begin
            bad++;
            $display("FAIL drain: %0d entries left, want 0", sbq.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
